// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter.
//   RF_WIDTH_DEF / RF_AW_DEF : default data and address widths
//   RF_SIZE_DEF              : default number of registers
//   rf_state_e               : write-port sequencer state encoding
package rf_pkg;

  localparam int RF_WIDTH_DEF = 32;
  localparam int RF_AW_DEF    = 5;
  localparam int RF_SIZE_DEF  = 1 << RF_AW_DEF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   en         : arbitration allowed this cycle
//   valid0/1   : requester valids
//   last_grant : index of the requester that won the previous transfer
//   gnt0/1     : one-hot (or zero) grant
module rf_rr_arb2 (
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt0 = en & valid0 & (~valid1 | last_grant);
    gnt1 = en & valid1 & (~valid0 | ~last_grant);
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the single register-file write port between two requesters and
// runs a clear sequence that writes zero to every register.
//   clk, rst           : clock, async active-high reset
//   req0_* / req1_*    : valid/ready write requests (addr, data)
//   clr_req            : start a clear sequence
//   clr_busy, clr_done : clear in progress / one-cycle completion pulse
//   wa, we, wd         : registered register-file write port
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH         = RF_WIDTH_DEF,
  parameter int REGFILE_WIDTH = RF_AW_DEF,
  parameter bit ZERO_R0       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [REGFILE_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]         req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [REGFILE_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]         req1_data,
  output logic                     req1_ready,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [REGFILE_WIDTH-1:0] wa,
  output logic                     we,
  output logic [WIDTH-1:0]         wd
);

  localparam int REGFILE_SIZE = 1 << REGFILE_WIDTH;
  localparam logic [REGFILE_WIDTH-1:0] LAST_ADDR = REGFILE_WIDTH'(REGFILE_SIZE - 1);

  rf_state_e                state, state_nxt;
  logic [REGFILE_WIDTH-1:0] clr_ptr;
  logic                     last_grant;
  logic                     arb_en, gnt0, gnt1;
  logic [REGFILE_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]         sel_data;

  // A clear request pre-empts arbitration in the same cycle it is seen.
  assign arb_en = (state == ST_IDLE) && !clr_req;

  rf_rr_arb2 u_arb (
    .en        (arb_en),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last_grant(last_grant),
    .gnt0      (gnt0),
    .gnt1      (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign clr_busy   = (state == ST_CLEAR);
  assign sel_addr   = gnt1 ? req1_addr : req0_addr;
  assign sel_data   = gnt1 ? req1_data : req0_data;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_ptr == LAST_ADDR) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa         <= '0;
      wd         <= '0;
      we         <= 1'b0;
      clr_done   <= 1'b0;
      clr_ptr    <= '0;
      last_grant <= 1'b1;
    end else begin
      we       <= 1'b0;
      clr_done <= 1'b0;
      if (state == ST_CLEAR) begin
        // Clear writes r0 too: ZERO_R0 only filters requester writes.
        wa <= clr_ptr;
        wd <= '0;
        we <= 1'b1;
        if (clr_ptr == LAST_ADDR) begin
          clr_ptr  <= '0;
          clr_done <= 1'b1;
        end else begin
          clr_ptr <= clr_ptr + 1'b1;
        end
      end else if (gnt0 || gnt1) begin
        // Address/data are captured even when the r0 write is suppressed.
        wa         <= sel_addr;
        wd         <= sel_data;
        we         <= !(ZERO_R0 && (sel_addr == '0));
        last_grant <= gnt1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic          clk, rst;
  logic          req0_valid, req1_valid, clr_req;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [W-1:0]  req0_data, req1_data;
  logic          req0_ready, req1_ready, clr_busy, clr_done, we;
  logic [AW-1:0] wa;
  logic [W-1:0]  wd;

  rf_wr_arbiter #(.WIDTH(W), .REGFILE_WIDTH(AW), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .wa(wa), .we(we), .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the pending write the port should be presenting, the clear
  // progress as a count of registers already written, and a shadow file.
  bit           m_clearing;
  int           m_cidx;
  int           m_last;
  bit           m_we;
  int           m_wa;
  logic [31:0]  m_wd;
  bit           m_done;
  logic [31:0]  mfile [N];
  logic [31:0]  dfile [N];
  bit           s_we;
  int           s_wa;
  logic [31:0]  s_wd;

  function automatic int winner();
    if (m_clearing || clr_req) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic m_reset();
    m_clearing = 0; m_cidx = 0; m_last = 1;
    m_we = 0; m_wa = 0; m_wd = 0; m_done = 0;
  endtask

  task automatic m_update();
    int g;
    g = winner();
    if (m_we) mfile[m_wa] = m_wd;
    m_done = 0;
    if (m_clearing) begin
      m_we = 1; m_wa = m_cidx; m_wd = 0;
      m_cidx++;
      if (m_cidx == N) begin m_clearing = 0; m_cidx = 0; m_done = 1; end
    end else if (clr_req) begin
      m_clearing = 1; m_cidx = 0; m_we = 0;
    end else if (g == 0) begin
      m_wa = int'(req0_addr); m_wd = req0_data; m_we = (req0_addr != 0); m_last = 0;
    end else if (g == 1) begin
      m_wa = int'(req1_addr); m_wd = req1_data; m_we = (req1_addr != 0); m_last = 1;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic model_checks();
    int g;
    g = winner();
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("we", 32'(we), 32'(m_we));
    if (m_we) begin
      chk("wa", 32'(wa), 32'(m_wa));
      chk("wd", wd, m_wd);
    end
    chk("clr_busy", 32'(clr_busy), 32'(m_clearing));
    chk("clr_done", 32'(clr_done), 32'(m_done));
  endtask

  task automatic sample_dut();
    s_we = (we === 1'b1); s_wa = int'(wa); s_wd = wd;
  endtask

  task automatic advance();
    @(posedge clk);
    if (s_we) dfile[s_wa] = s_wd;
    if (!rst) m_update();
    #1;
  endtask

  task automatic step_model();
    @(negedge clk);
    model_checks();
    sample_dut();
    advance();
  endtask

  task automatic drive(input bit v0, input logic [AW-1:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [AW-1:0] a1, input logic [31:0] d1,
                       input bit clr);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clr_req = clr;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit v0; logic [AW-1:0] a0; logic [31:0] d0;
    bit v1; logic [AW-1:0] a1; logic [31:0] d1;
    bit r0; bit r1; bit we; bit chk_ad; logic [AW-1:0] wa; logic [31:0] wd;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit v0, logic [AW-1:0] a0, logic [31:0] d0,
                              bit v1, logic [AW-1:0] a1, logic [31:0] d1,
                              bit r0, bit r1, bit e, bit ca, logic [AW-1:0] ea, logic [31:0] ed);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.we = e; v.chk_ad = ca; v.wa = ea; v.wd = ed;
    return v;
  endfunction

  logic [31:0] old [N];

  initial begin
    bit seen, hit, p0, p1;
    int busy_cnt, wcnt;

    for (int i = 0; i < N; i++) begin
      dfile[i] = 32'hA500_0000 | i;
      mfile[i] = dfile[i];
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    s_we = 0;

    #3;
    chk("rst_we", 32'(we), 0);
    chk("rst_wa", 32'(wa), 0);
    chk("rst_wd", wd, 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // contention (after reset req0 wins first), single write, r0 suppression
    tbl.push_back(mk(1, 1, 32'h11, 1, 3, 32'h33,       1, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(1, 2, 32'h22, 1, 3, 32'h33,       0, 1, 1, 1, 1, 32'h11));
    tbl.push_back(mk(1, 2, 32'h22, 1, 4, 32'h44,       1, 0, 1, 1, 3, 32'h33));
    tbl.push_back(mk(1, 6, 32'h66, 1, 4, 32'h44,       0, 1, 1, 1, 2, 32'h22));
    tbl.push_back(mk(1, 6, 32'h66, 0, 0, 0,            1, 0, 1, 1, 4, 32'h44));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,            0, 0, 1, 1, 6, 32'h66));
    tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,            0, 0, 1, 1, 5, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0,      1, 0, 32'h1234,     0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,            0, 0, 0, 1, 0, 32'h1234));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0, 32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_r0", i), 32'(req0_ready), 32'(tbl[i].r0));
      chk($sformatf("vec%0d_r1", i), 32'(req1_ready), 32'(tbl[i].r1));
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(tbl[i].we));
      if (tbl[i].chk_ad) begin
        chk($sformatf("vec%0d_wa", i), 32'(wa), 32'(tbl[i].wa));
        chk($sformatf("vec%0d_wd", i), wd, tbl[i].wd);
      end
      model_checks();
      sample_dut();
      advance();
    end
    chk("r0_kept", dfile[0], 32'hA500_0000);
    chk("r5_written", dfile[5], 32'hDEADBEEF);

    // preload r7, then a clear pulse with both requesters waiting
    drive(1, 7, 32'h55, 0, 0, 0, 0);
    step_model();
    drive(0, 0, 0, 0, 0, 0, 0);
    step_model();
    step_model();
    chk("r7_preload", dfile[7], 32'h55);

    drive(1, 8, 32'h88, 1, 9, 32'h99, 1);
    @(negedge clk);
    chk("clr_entry_r0", 32'(req0_ready), 0);
    chk("clr_entry_r1", 32'(req1_ready), 0);
    model_checks(); sample_dut(); advance();
    clr_req = 1'b0;
    seen = 0; busy_cnt = 0; wcnt = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      model_checks();
      if (clr_busy) begin
        busy_cnt++;
        chk("clr_busy_r0", 32'(req0_ready), 0);
        chk("clr_busy_r1", 32'(req1_ready), 0);
      end
      if ((clr_busy || clr_done) && we) begin
        chk("clr_wa_seq", 32'(wa), 32'(wcnt));
        chk("clr_wd_zero", wd, 0);
        wcnt++;
      end
      if (clr_done) begin
        seen = 1;
        chk("clr_done_wa", 32'(wa), 31);
        chk("clr_done_we", 32'(we), 1);
        chk("clr_done_busy", 32'(clr_busy), 0);
      end
      sample_dut(); advance();
    end
    chk("clr_done_seen", 32'(seen), 1);
    chk("clr_busy_cycles", 32'(busy_cnt), 32);
    chk("clr_write_count", 32'(wcnt), 32);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step_model();
    chk("r7_cleared", dfile[7], 0);

    // clear and request on the same edge: request waits for the clear
    drive(1, 12, 32'h1200C, 0, 0, 0, 1);
    @(negedge clk);
    chk("cvr_r0_blocked", 32'(req0_ready), 0);
    model_checks(); sample_dut(); advance();
    clr_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      model_checks();
      if (clr_busy) chk("cvr_r0_wait", 32'(req0_ready), 0);
      if (clr_done) begin
        seen = 1;
        chk("cvr_grant", 32'(req0_ready), 1);
      end
      sample_dut(); advance();
    end
    chk("cvr_done_seen", 32'(seen), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) step_model();
    chk("cvr_r12", dfile[12], 32'h1200C);

    // randomized traffic; requesters hold while stalled
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_addr  = AW'($urandom_range(0, N - 1));
        req0_data  = $urandom;
      end
      if (!p1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_addr  = AW'($urandom_range(0, N - 1));
        req1_data  = $urandom;
      end
      clr_req = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      model_checks();
      p0 = req0_valid && (winner() != 0);
      p1 = req1_valid && (winner() != 1);
      sample_dut(); advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 40 && m_clearing; c++) step_model();
    repeat (2) step_model();
    for (int i = 0; i < N; i++) chk($sformatf("file_r%0d", i), dfile[i], mfile[i]);

    // fill every register, then reset in the middle of a clear
    for (int a = 0; a < N; a++) begin
      drive(0, 0, 0, 1, AW'(a), 32'hC0DE_0000 | a, 0);
      step_model();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) step_model();
    for (int i = 0; i < N; i++) old[i] = dfile[i];

    clr_req = 1'b1;
    step_model();
    clr_req = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (we === 1'b1 && wa == 10) begin
        #2 rst = 1'b1;
        #1;
        chk("rmc_we", 32'(we), 0);
        chk("rmc_busy", 32'(clr_busy), 0);
        chk("rmc_done", 32'(clr_done), 0);
        m_reset();
        s_we = 0;
        hit = 1;
      end else begin
        model_checks(); sample_dut(); advance();
      end
    end
    chk("rmc_reached", 32'(hit), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rmc_we_after", 32'(we), 0);
    chk("rmc_busy_after", 32'(clr_busy), 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rmc_r%0d", i), dfile[i], (i < 10) ? 32'h0 : old[i]);
      chk($sformatf("rmc_model_r%0d", i), dfile[i], mfile[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
